// File: rtl/phy_tx_sched.sv
// Two-lane round-robin byte scheduler feeding an 8-bit serializer slot on clk_32f.
// Optional idle-slot counter: define PHY_TX_SCHED_IDLE_CNT_EN to add idle_cnt_out.
module phy_tx_sched #(
    parameter int unsigned SYNC_SLOTS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data0_in,
    input  logic       valid0_in,
    output logic       ready0_out,
    input  logic [7:0] data1_in,
    input  logic       valid1_in,
    output logic       ready1_out,
    input  logic       resync_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_out,
    output logic       slot_start_out,
    output logic       active_out
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
    ,
    output logic [15:0] idle_cnt_out
`endif
);

    localparam logic [7:0] IDLE_BYTE = 8'hBC;
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_SLOTS - 1);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt;
    logic [7:0] sync_cnt_q, sync_cnt_d;
    logic       last_lane;
    logic       slot_end;
    logic       grant0, grant1;
    logic       take_resync;

    assign slot_end = (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            sync_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    // Arbitration happens only in the last bit of a slot; the final SYNC slot
    // already arbitrates so the first byte lands exactly in slot SYNC_SLOTS.
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        take_resync = 1'b0;
        if (slot_end) begin
            if (resync_in) begin
                state_d     = SYNC;
                sync_cnt_d  = 8'd0;
                take_resync = 1'b1;
            end else if (state_q == SYNC && sync_cnt_q != SYNC_LAST) begin
                sync_cnt_d = sync_cnt_q + 8'd1;
            end else begin
                state_d    = ACTIVE;
                sync_cnt_d = 8'd0;
                grant0     = valid0_in && (!valid1_in || last_lane);
                grant1     = valid1_in && (!valid0_in || !last_lane);
            end
        end
    end

    assign ready0_out     = grant0 & ~reset;
    assign ready1_out     = grant1 & ~reset;
    assign slot_start_out = (bit_cnt == 3'd0) & ~reset;
    assign active_out     = (state_q == ACTIVE);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            last_lane <= 1'b1;
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
            lane_out  <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (slot_end) begin
                if (grant0) begin
                    data_out  <= data0_in;
                    valid_out <= 1'b1;
                    lane_out  <= 1'b0;
                    last_lane <= 1'b0;
                end else if (grant1) begin
                    data_out  <= data1_in;
                    valid_out <= 1'b1;
                    lane_out  <= 1'b1;
                    last_lane <= 1'b1;
                end else begin
                    data_out  <= IDLE_BYTE;
                    valid_out <= 1'b0;
                    lane_out  <= 1'b0;
                end
            end
        end
    end

`ifdef PHY_TX_SCHED_IDLE_CNT_EN
    // Counts idle slots that begin in ACTIVE, including the first slot after sync.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            idle_cnt_out <= 16'd0;
        end else if (take_resync) begin
            idle_cnt_out <= 16'd0;
        end else if (slot_end && state_d == ACTIVE && !grant0 && !grant1
                     && idle_cnt_out != 16'hFFFF) begin
            idle_cnt_out <= idle_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: slot-level behavioural model checked every cycle plus directed literal checks.
module tb_phy_tx_sched;

    localparam int SYNC = 4;

    logic       clk_32f, reset;
    logic [7:0] data0_in, data1_in;
    logic       valid0_in, valid1_in, ready0_out, ready1_out;
    logic       resync_in;
    logic [7:0] data_out;
    logic       valid_out, lane_out, slot_start_out, active_out;
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
    logic [15:0] idle_cnt_out;
`endif

    phy_tx_sched #(.SYNC_SLOTS(SYNC)) dut (
        .clk_32f(clk_32f), .reset(reset),
        .data0_in(data0_in), .valid0_in(valid0_in), .ready0_out(ready0_out),
        .data1_in(data1_in), .valid1_in(valid1_in), .ready1_out(ready1_out),
        .resync_in(resync_in), .data_out(data_out), .valid_out(valid_out),
        .lane_out(lane_out), .slot_start_out(slot_start_out), .active_out(active_out)
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
        , .idle_cnt_out(idle_cnt_out)
`endif
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: slots of 8 cycles; m_left = idle sync slots still to go (0 = active).
    int         m_cyc, m_left, m_idle, m_g;
    logic       m_last, m_valid, m_lane;
    logic [7:0] m_data;
    bit         m_init = 0;

    function automatic int pick();
        if (m_cyc % 8 != 7 || resync_in || m_left > 1) return -1;
        if (valid0_in && (!valid1_in || m_last)) return 0;
        if (valid1_in) return 1;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk_32f or posedge reset);
            if (reset) begin
                m_init = 1; m_cyc = 0; m_left = SYNC; m_idle = 0;
                m_last = 1; m_data = 8'hBC; m_valid = 0; m_lane = 0;
            end else if (m_init) begin
                if (m_cyc % 8 == 7) begin
                    m_g = pick();
                    m_data = 8'hBC; m_valid = 0; m_lane = 0;
                    if (resync_in) begin
                        m_left = SYNC; m_idle = 0;
                    end else if (m_left > 1) begin
                        m_left--;
                    end else begin
                        m_left = 0;
                        if (m_g == 0) begin
                            m_data = data0_in; m_valid = 1; m_lane = 0; m_last = 0;
                        end else if (m_g == 1) begin
                            m_data = data1_in; m_valid = 1; m_lane = 1; m_last = 1;
                        end else if (m_idle < 65535) begin
                            m_idle++;
                        end
                    end
                end
                m_cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_32f);
            if (m_init) begin
                chk("m_data", 32'(data_out), 32'(m_data));
                chk("m_valid", 32'(valid_out), 32'(m_valid));
                chk("m_lane", 32'(lane_out), 32'(m_lane));
                chk("m_active", 32'(active_out), 32'(m_left == 0));
                chk("m_slot_start", 32'(slot_start_out), 32'(!reset && m_cyc % 8 == 0));
                chk("m_ready0", 32'(ready0_out), 32'(!reset && pick() == 0));
                chk("m_ready1", 32'(ready1_out), 32'(!reset && pick() == 1));
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
                chk("m_idle_cnt", 32'(idle_cnt_out), 32'(m_idle));
`endif
            end
        end
    end

    // Source side: per-lane byte queues, popped on each accepted transfer.
    logic [7:0] q0[$], q1[$];
    int tcyc;

    task automatic present();
        valid0_in = (q0.size() > 0);
        data0_in  = (q0.size() > 0) ? q0[0] : 8'h00;
        valid1_in = (q1.size() > 0);
        data1_in  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic step();
        logic a0, a1;
        @(negedge clk_32f);
        a0 = valid0_in && ready0_out;
        a1 = valid1_in && ready1_out;
        @(posedge clk_32f);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        present();
        tcyc++;
    endtask

    task automatic goto(input int slot, input int bitn);
        while (tcyc < slot * 8 + bitn) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        present();
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        tcyc  = 0;
        #1;
    endtask

    initial begin
        reset = 1'b1; resync_in = 1'b0;
        q0.delete(); q1.delete();
        present();
        repeat (2) @(posedge clk_32f);
        #1;
        chk("rst_data", 32'(data_out), 32'h0BC);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_active", 32'(active_out), 32'h0);
        chk("rst_slot_start", 32'(slot_start_out), 32'h0);
        chk("rst_ready0", 32'(ready0_out), 32'h0);

        // Idle only: activates after 4 slots, never grants.
        do_reset();
        chk("rel_slot_start", 32'(slot_start_out), 32'h1);
        goto(3, 7);
        chk("idle_active_s3", 32'(active_out), 32'h0);
        goto(4, 1);
        chk("idle_active_s4", 32'(active_out), 32'h1);
        chk("idle_data_s4", 32'(data_out), 32'h0BC);
        goto(6, 1);
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
        chk("idle_cnt_3", 32'(idle_cnt_out), 32'd3);
`endif
        goto(6, 7);
        resync_in = 1'b1;
        step();
        resync_in = 1'b0;
`ifdef PHY_TX_SCHED_IDLE_CNT_EN
        chk("idle_cnt_clr", 32'(idle_cnt_out), 32'd0);
`endif
        chk("idle_resync_active", 32'(active_out), 32'h0);
        goto(12, 0);

        // Lane 0 only.
        q0 = '{8'hA5, 8'h3C};
        do_reset();
        goto(3, 7);
        chk("l0_ready_s3b7", 32'(ready0_out), 32'h1);
        goto(4, 2);
        chk("l0_data_s4", 32'(data_out), 32'h0A5);
        chk("l0_lane_s4", 32'(lane_out), 32'h0);
        goto(4, 6);
        chk("l0_ready_s4b6", 32'(ready0_out), 32'h0);
        goto(5, 2);
        chk("l0_data_s5", 32'(data_out), 32'h03C);
        goto(6, 2);
        chk("l0_valid_s6", 32'(valid_out), 32'h0);

        // Contention: alternation starting with lane 0.
        q0 = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        q1 = '{8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
        do_reset();
        goto(4, 4); chk("rr_s4", 32'(data_out), 32'h011);
        goto(5, 4); chk("rr_s5", 32'(data_out), 32'h022);
        goto(6, 4); chk("rr_s6", 32'(data_out), 32'h011);
        goto(7, 4); chk("rr_s7", 32'(data_out), 32'h022);
        chk("rr_lane_s7", 32'(lane_out), 32'h1);

        // Resync at end of slot 6 under contention.
        q0 = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        q1 = '{8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
        do_reset();
        goto(6, 7);
        resync_in = 1'b1;
        #1;
        chk("rs_ready0", 32'(ready0_out), 32'h0);
        chk("rs_ready1", 32'(ready1_out), 32'h0);
        step();
        resync_in = 1'b0;
        goto(8, 3);
        chk("rs_active_s8", 32'(active_out), 32'h0);
        chk("rs_valid_s8", 32'(valid_out), 32'h0);
        goto(10, 7);
        chk("rs_ready1_s10", 32'(ready1_out), 32'h1);
        goto(11, 1);
        chk("rs_data_s11", 32'(data_out), 32'h022);
        chk("rs_active_s11", 32'(active_out), 32'h1);

        // Reset mid-slot while A5 is displayed.
        q0 = '{8'hA5, 8'h3C};
        q1.delete();
        do_reset();
        goto(4, 3);
        chk("mr_data_before", 32'(data_out), 32'h0A5);
        reset = 1'b1;
        #1;
        chk("mr_data", 32'(data_out), 32'h0BC);
        chk("mr_valid", 32'(valid_out), 32'h0);
        chk("mr_lane", 32'(lane_out), 32'h0);
        chk("mr_ready0", 32'(ready0_out), 32'h0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        tcyc  = 0;
        #1;
        chk("mr_slot_start", 32'(slot_start_out), 32'h1);
        goto(0, 1);
        chk("mr_slot_start_b1", 32'(slot_start_out), 32'h0);
        goto(4, 2);
        chk("mr_data_s4", 32'(data_out), 32'h03C);
        goto(6, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_tx_sched.md
# phy_tx_sched

Two-lane byte scheduler for the PHY transmit path, running on `clk_32f` ahead of the parallel-to-serial converter. It tracks the serializer's 8-cycle byte slot and sends an idle sequence after reset. It then arbitrates round-robin between two byte sources using a valid/ready handshake, and presents one byte per slot. Bytes stay stable for the whole slot so the serializer can shift them out MSB-first.

## Interface
- `SYNC_SLOTS`, 4: number of idle slots emitted after reset or resync before any grant; legal range 1..255.
- `clk_32f` in 1: bit clock; one serial bit per cycle.
- `reset` in 1: asynchronous, active-high reset.
- `data0_in` in 8: lane 0 byte.
- `valid0_in` in 1: lane 0 byte available.
- `ready0_out` out 1: lane 0 byte accepted at the next rising edge.
- `data1_in` in 8, `valid1_in` in 1, `ready1_out` out 1: lane 1, same semantics as lane 0.
- `resync_in` in 1: request to return to the idle/sync sequence; sampled at slot boundaries.
- `data_out` out 8: byte for the current slot; 8'hBC when idle.
- `valid_out` out 1: the current slot carries lane data.
- `lane_out` out 1: source lane of the current slot's byte.
- `slot_start_out` out 1: high in the first cycle of each slot (`bit_cnt==0`).
- `active_out` out 1: the scheduler is in ACTIVE.

## Operation
- `bit_cnt` is a 3-bit, free-running counter, 0..7, wrapping 7→0 every 8 cycles. It stays aligned with the serializer's bit index because both are cleared by reset.
- A slot boundary is the rising edge at which `bit_cnt` goes 7→0. `data_out`, `valid_out` and `lane_out` are registered and change only at slot boundaries.
- State machine:
  - SYNC: no grants. Every slot is idle (`valid_out=0`, `data_out=8'hBC`). `sync_cnt` counts completed idle slots. At the boundary ending slot `SYNC_SLOTS-1`, the block moves to ACTIVE and a grant is already permitted at that boundary.
  - ACTIVE: one arbitration per slot, evaluated in the `bit_cnt==7` cycle.
  - ACTIVE→SYNC: when `resync_in`=1 in the `bit_cnt==7` cycle. There is no grant that cycle, `sync_cnt` reloads to 0, and the next slot is idle.
- Arbitration, in the `bit_cnt==7` cycle, when ACTIVE or when the SYNC→ACTIVE transition is due:
  - Exactly one valid lane: grant that lane.
  - Both lanes valid: grant the lane ≠ `last_lane`.
  - Neither valid: no grant; the next slot is idle.
- Handshake:
  - `readyN_out` = grant to lane N. It is combinational and high only in a `bit_cnt==7` cycle.
  - A transfer occurs on the rising edge where `validN_in && readyN_out`.
  - At that edge, `data_out` ← `dataN_in`, `valid_out` ← 1, `lane_out` ← N, `last_lane` ← N.
  - Sources must hold valid and data until a transfer occurs. Valid must not depend on ready.
- A grant is refused (both readys 0) when `resync_in`=1 in the same cycle; resync wins.
- Reset, including mid-slot or mid-transfer, asynchronously clears all state:
  - `bit_cnt`=0, state=SYNC, `sync_cnt`=0, `last_lane`=1 (so lane 0 wins the first tie).
  - `data_out`=8'hBC, `valid_out`=0, `lane_out`=0, `active_out`=0.
  - `ready0_out`=`ready1_out`=0, `slot_start_out`=0 while reset is high.
  - A byte presented during reset is not consumed.

## Timing
- Slot 0 begins at reset deassertion. Slots are 8 `clk_32f` cycles each.
- Earliest ready is in the `bit_cnt==7` cycle of slot `SYNC_SLOTS-1`. The first byte appears on `data_out` in slot `SYNC_SLOTS`.
- Latency from accept edge to `data_out` is 0 cycles, since the byte is registered at the accept edge. The byte is held for 8 cycles.
- Maximum throughput is one byte per slot, aggregate across both lanes. Under continuous contention, each lane gets every other slot.
- `active_out` rises at the SYNC→ACTIVE boundary. It falls at the boundary where resync is taken.
- `slot_start_out` = (`bit_cnt==0`) & ~`reset`.

## Configuration
- `PHY_TX_SCHED_IDLE_CNT_EN` defined:
  - Adds output `idle_cnt_out[15:0]`, which counts idle slots issued while ACTIVE. SYNC slots are not counted.
  - The counter increments at the boundary that starts the idle slot and saturates at 16'hFFFF.
  - It is cleared by reset and by taking resync.
- `PHY_TX_SCHED_IDLE_CNT_EN` not defined: the port and the counter do not exist, and all other behaviour is identical.

## Test plan
- Reset release, no valids, `SYNC_SLOTS`=4: 4 idle slots, then `active_out`=1 with `data_out`=8'hBC and `valid_out`=0 indefinitely; `ready` is never high.
- Lane 0 only, bytes 8'hA5 then 8'h3C held valid:
  - 8'hA5 is presented in slot 4 and 8'h3C in slot 5, each for 8 cycles with `lane_out`=0.
  - `ready0_out` pulses exactly in the `bit_cnt==7` cycles.
- Both lanes continuously valid (lane 0 = 8'h11, lane 1 = 8'h22): slots 4, 5, 6, 7 carry 11, 22, 11, 22.
- `resync_in` pulsed in the `bit_cnt==7` cycle of slot 6 with both lanes valid:
  - No ready that cycle.
  - Slots 7..10 are idle with `active_out`=0.
  - Grants resume at the end of slot 10.
- Reset asserted at `bit_cnt`=3 while 8'hA5 is displayed: outputs go immediately to 8'hBC/0/0, and `bit_cnt` restarts at 0 after release.
- With `PHY_TX_SCHED_IDLE_CNT_EN`: 3 idle ACTIVE slots give `idle_cnt_out`=3, and a resync clears it to 0.
